// File: rtl/fwd_mux_reg.sv
// N:1 operand-forwarding mux with a registered output, stall capture and flush.
// Latency: 1 cycle from in_i/sel_i to out_o while passing.
// Backpressure: stall_i freezes out_o and captures the first-cycle selection until release.
module fwd_mux_reg #(
    parameter int  WIDTH   = 32,
    parameter int  NUM_SRC = 3,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_SRC*WIDTH-1:0] in_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic                     in_valid_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         out_o,
    output logic                     out_valid_o,
    output logic                     held_o
);

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   hold_data_q, hold_data_d;
    logic               hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]   sel_data;

    // Out-of-range selects fall through to source 0.
    always_comb begin
        sel_data = in_i[WIDTH-1:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (sel_i == SEL_W'(k)) begin
                sel_data = in_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        if (flush_i) begin
            state_d      = PASS;
            out_d        = '0;
            out_valid_d  = 1'b0;
            hold_data_d  = '0;
            hold_valid_d = 1'b0;
        end else begin
            case (state_q)
                PASS: begin
                    if (stall_i) begin
                        hold_data_d  = sel_data;
                        hold_valid_d = in_valid_i;
                        state_d      = HOLD;
                    end else begin
                        out_d       = sel_data;
                        out_valid_d = in_valid_i;
                    end
                end
                HOLD: begin
                    // Release drains the captured operand; live data waits one more edge.
                    if (!stall_i) begin
                        out_d       = hold_data_q;
                        out_valid_d = hold_valid_q;
                        state_d     = PASS;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= PASS;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign held_o      = (state_q == HOLD);

endmodule
